axi_lite_timeout_guard: RTL

- Sits on one master port of the 32-bit AXI4-Lite config crossbar, between the crossbar and a config slave (LLC cfg, TLB cfg, PMU cfg).
- Passes traffic through unchanged and watches the response phase.
- If the slave does not answer within TimeoutCycles, it returns SLVERR upstream, then absorbs the late response.
- Keeps the crossbar and the host/cluster masters from hanging on a dead slave.

---
 rtl/axi_lite_timeout_guard_pkg.sv | 54 +++++
 rtl/axi_lite_resp_timer.sv | 93 +++++++++
 rtl/axi_lite_timeout_guard.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_timeout_guard_pkg.sv
// rtl/axi_lite_timeout_guard_pkg.sv - AXI4-Lite lite types, response codes and timer states
package axi_lite_timeout_guard_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_lite_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_lite_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_lite_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_lite_t;

    typedef struct packed {
        ax_lite_t aw;
        logic     aw_valid;
        w_lite_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_lite_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_lite_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_lite_t b;
        logic    b_valid;
        logic    ar_ready;
        r_lite_t r;
        logic    r_valid;
    } resp_lite_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_WAIT,
        T_ERR,
        T_DRAIN
    } timer_state_e;

endpackage

// File: rtl/axi_lite_resp_timer.sv
// rtl/axi_lite_resp_timer.sv - response-phase watchdog: WAIT/ERR/DRAIN FSM with cycle counter
module axi_lite_resp_timer
    import axi_lite_timeout_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic resp_valid_i,
    input  logic resp_ready_i,
    output logic idle_o,
    output logic fwd_en_o,
    output logic err_valid_o,
    output logic drain_ready_o,
    output logic timeout_pulse_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;
    // The error response must be visible TimeoutCycles after the start edge, so the
    // last waiting cycle is the one where the counter sits at TimeoutCycles-2.
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 2);

    if (TimeoutCycles < 2) begin : g_param_check
        $error("axi_lite_resp_timer: TimeoutCycles must be >= 2");
    end

    timer_state_e        state_q, state_d;
    logic [CntWidth-1:0] timer_q, timer_d;
    logic                drained_q, drained_d;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        drained_d       = drained_q;
        idle_o          = 1'b0;
        fwd_en_o        = 1'b0;
        err_valid_o     = 1'b0;
        drain_ready_o   = 1'b0;
        timeout_pulse_o = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                idle_o = 1'b1;
                if (start_i) begin
                    state_d = T_WAIT;
                    timer_d = '0;
                end
            end
            T_WAIT: begin
                fwd_en_o = 1'b1;
                if (resp_valid_i && resp_ready_i) begin
                    state_d = T_IDLE;
                end else if (timer_q == LastCnt && !resp_valid_i) begin
                    state_d         = T_ERR;
                    drained_d       = 1'b0;
                    timeout_pulse_o = 1'b1;
                end else if (timer_q != LastCnt) begin
                    timer_d = timer_q + CntWidth'(1);
                end
            end
            T_ERR: begin
                err_valid_o   = 1'b1;
                drain_ready_o = 1'b1;
                if (resp_valid_i) begin
                    drained_d = 1'b1;
                end
                if (resp_ready_i) begin
                    state_d = (drained_q || resp_valid_i) ? T_IDLE : T_DRAIN;
                end
            end
            T_DRAIN: begin
                drain_ready_o = 1'b1;
                if (resp_valid_i) begin
                    state_d = T_IDLE;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= T_IDLE;
            timer_q   <= '0;
            drained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            drained_q <= drained_d;
        end
    end

endmodule

// File: rtl/axi_lite_timeout_guard.sv
// rtl/axi_lite_timeout_guard.sv - AXI4-Lite pass-through that answers SLVERR for a silent slave
module axi_lite_timeout_guard
    import axi_lite_timeout_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [31:0] ErrData       = 32'hBADC_AB1E,
    parameter type         req_lite_t    = axi_lite_timeout_guard_pkg::req_lite_t,
    parameter type         resp_lite_t   = axi_lite_timeout_guard_pkg::resp_lite_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  req_lite_t  slv_req_i,
    output resp_lite_t slv_resp_o,
    output req_lite_t  mst_req_o,
    input  resp_lite_t mst_resp_i,
    input  logic       clr_i,
    output logic       timeout_irq_o,
    output logic [7:0] wr_to_cnt_o,
    output logic [7:0] rd_to_cnt_o
);

    logic w_idle, w_fwd, w_err, w_drain, w_pulse;
    logic r_idle, r_fwd, r_err, r_drain, r_pulse;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic aw_open, w_open, aw_hs, w_hs, w_start, r_start;
    logic       irq_q, irq_d;
    logic [7:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    // Each channel closes after its handshake so a second AW or W cannot slip in
    // while the join waits for its partner.
    assign aw_open = w_idle && !aw_done_q;
    assign w_open  = w_idle && !w_done_q;
    assign aw_hs   = aw_open && slv_req_i.aw_valid && mst_resp_i.aw_ready;
    assign w_hs    = w_open && slv_req_i.w_valid && mst_resp_i.w_ready;
    assign w_start = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign r_start = r_idle && slv_req_i.ar_valid && mst_resp_i.ar_ready;

    assign aw_done_d = w_start ? 1'b0 : (aw_done_q || aw_hs);
    assign w_done_d  = w_start ? 1'b0 : (w_done_q || w_hs);

    axi_lite_resp_timer #(.TimeoutCycles(TimeoutCycles)) u_b_timer (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (w_start),
        .resp_valid_i   (mst_resp_i.b_valid),
        .resp_ready_i   (slv_req_i.b_ready),
        .idle_o         (w_idle),
        .fwd_en_o       (w_fwd),
        .err_valid_o    (w_err),
        .drain_ready_o  (w_drain),
        .timeout_pulse_o(w_pulse)
    );

    axi_lite_resp_timer #(.TimeoutCycles(TimeoutCycles)) u_r_timer (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (r_start),
        .resp_valid_i   (mst_resp_i.r_valid),
        .resp_ready_i   (slv_req_i.r_ready),
        .idle_o         (r_idle),
        .fwd_en_o       (r_fwd),
        .err_valid_o    (r_err),
        .drain_ready_o  (r_drain),
        .timeout_pulse_o(r_pulse)
    );

    always_comb begin
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;

        mst_req_o.aw_valid  = aw_open && slv_req_i.aw_valid;
        mst_req_o.w_valid   = w_open && slv_req_i.w_valid;
        mst_req_o.ar_valid  = r_idle && slv_req_i.ar_valid;
        slv_resp_o.aw_ready = aw_open && mst_resp_i.aw_ready;
        slv_resp_o.w_ready  = w_open && mst_resp_i.w_ready;
        slv_resp_o.ar_ready = r_idle && mst_resp_i.ar_ready;

        slv_resp_o.b_valid = 1'b0;
        mst_req_o.b_ready  = 1'b0;
        if (w_fwd) begin
            slv_resp_o.b_valid = mst_resp_i.b_valid;
            mst_req_o.b_ready  = slv_req_i.b_ready;
        end else if (w_err) begin
            slv_resp_o.b_valid = 1'b1;
            slv_resp_o.b.resp  = RESP_SLVERR;
            mst_req_o.b_ready  = 1'b1;
        end else if (w_drain) begin
            mst_req_o.b_ready = 1'b1;
        end

        slv_resp_o.r_valid = 1'b0;
        mst_req_o.r_ready  = 1'b0;
        if (r_fwd) begin
            slv_resp_o.r_valid = mst_resp_i.r_valid;
            mst_req_o.r_ready  = slv_req_i.r_ready;
        end else if (r_err) begin
            slv_resp_o.r_valid = 1'b1;
            slv_resp_o.r.data  = ErrData;
            slv_resp_o.r.resp  = RESP_SLVERR;
            mst_req_o.r_ready  = 1'b1;
        end else if (r_drain) begin
            mst_req_o.r_ready = 1'b1;
        end
    end

    // Clear takes effect first, so a timeout in the clear cycle still counts once.
    always_comb begin
        wr_cnt_d = clr_i ? 8'd0 : wr_cnt_q;
        rd_cnt_d = clr_i ? 8'd0 : rd_cnt_q;
        irq_d    = clr_i ? 1'b0 : irq_q;
        if (w_pulse && wr_cnt_d != 8'hFF) begin
            wr_cnt_d = wr_cnt_d + 8'd1;
        end
        if (r_pulse && rd_cnt_d != 8'hFF) begin
            rd_cnt_d = rd_cnt_d + 8'd1;
        end
        if (w_pulse || r_pulse) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_cnt_q  <= 8'd0;
            rd_cnt_q  <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign timeout_irq_o = irq_q;
    assign wr_to_cnt_o   = wr_cnt_q;
    assign rd_to_cnt_o   = rd_cnt_q;

endmodule
